// File: rtl/sp_mem_pkg.sv
// Shared defaults and FSM state encoding for the single-port data memory
// with registered response path.
package sp_mem_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 4096;

  typedef logic [0:0] state_t;
  localparam state_t INIT  = 1'b0;
  localparam state_t READY = 1'b1;

endpackage

// File: rtl/sp_data_mem_resp_if.sv
// Processor-side request/response bundle for sp_data_mem_resp.
// The processor drives through the master modport; the memory is the slave.
interface sp_data_mem_resp_if #(
  parameter int ADDR_W = sp_mem_pkg::ADDR_W_DEF,
  parameter int DATA_W = sp_mem_pkg::DATA_W_DEF
);

  logic              req_valid;
  logic              mem_wen;      // active-low: 0 = write, 1 = read
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din;
  logic [DATA_W-1:0] mem_dout;
  logic              resp_valid;
  logic              busy;
  logic              req_dropped;

  modport master (
    output req_valid, mem_wen, mem_addr, mem_din,
    input  mem_dout, resp_valid, busy, req_dropped
  );

  modport slave (
    input  req_valid, mem_wen, mem_addr, mem_din,
    output mem_dout, resp_valid, busy, req_dropped
  );

endinterface

// File: rtl/sp_mem_array.sv
// Single-port synchronous RAM: one write or one read per enabled cycle,
// read data registered in q.
module sp_mem_array #(
  parameter int ADDR_W = sp_mem_pkg::ADDR_W_DEF,
  parameter int DATA_W = sp_mem_pkg::DATA_W_DEF,
  parameter int DEPTH  = sp_mem_pkg::DEPTH_DEF
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto a RAM macro; the
  // only way to clear it is to write it.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= d;
      else    q         <= mem[addr];
    end
  end

endmodule

// File: rtl/sp_data_mem_resp.sv
// Data memory with fixed two-cycle read response, INIT clear sweep and
// sticky drop flag. Define DMEM_INIT_EN to clear the array after every reset.
module sp_data_mem_resp
  import sp_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input logic               clk,
  input logic               rst,
  sp_data_mem_resp_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            state;
  logic [ADDR_W-1:0] init_cnt;
  logic              rd_pipe;
  logic              accept;
  logic              arr_en;
  logic              arr_we;
  logic [ADDR_W-1:0] arr_addr;
  logic [DATA_W-1:0] arr_d;
  logic [DATA_W-1:0] arr_q;

  assign bus.busy = (state == INIT);
  assign accept   = bus.req_valid && !bus.busy && !rst;

  // The sweep owns the single RAM port while busy; requests own it otherwise.
  // NOTE: every output gets a default first so no latch is inferred.
  always_comb begin
    arr_en   = 1'b0;
    arr_we   = 1'b0;
    arr_addr = bus.mem_addr;
    arr_d    = bus.mem_din;
    if (state == INIT) begin
      arr_en   = !rst;
      arr_we   = 1'b1;
      arr_addr = init_cnt;
      arr_d    = '0;
    end else begin
      arr_en   = accept;
      arr_we   = !bus.mem_wen;
    end
  end

  sp_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk  (clk),
    .en   (arr_en),
    .we   (arr_we),
    .addr (arr_addr),
    .d    (arr_d),
    .q    (arr_q)
  );

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
`ifdef DMEM_INIT_EN
      state <= INIT;
`else
      state <= READY;
`endif
      init_cnt        <= '0;
      rd_pipe         <= 1'b0;
      bus.resp_valid  <= 1'b0;
      bus.mem_dout    <= '0;
      bus.req_dropped <= 1'b0;
    end else begin
      // Clearing rd_pipe on reset is what discards reads still in flight.
      rd_pipe        <= accept && bus.mem_wen;
      bus.resp_valid <= rd_pipe;
      if (rd_pipe) bus.mem_dout <= arr_q;
      if (bus.req_valid && bus.busy) bus.req_dropped <= 1'b1;
`ifdef DMEM_INIT_EN
      if (state == INIT) begin
        init_cnt <= init_cnt + 1'b1;
        if (init_cnt == LAST_ADDR) state <= READY;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sp_data_mem_resp.sv
// Randomized self-checking bench for sp_data_mem_resp against a
// transaction-level model (associative memory + response queue).
module tb_sp_data_mem_resp;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4096;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sp_data_mem_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sp_data_mem_resp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic [31:0] data;
    bit          known;
  } resp_t;

  resp_t       pend[$];
  logic [31:0] exp_mem[int];
  bit          mem_zeroed  = 1'b0;
  int          busy_left   = 0;
  bit          exp_dropped = 1'b0;
  logic [31:0] exp_dout    = '0;
  bit          dout_known  = 1'b0;
  bit          started     = 1'b0;
  int          cyc         = 0;

  // A read presented in the cycle ending at edge n is visible in the cycle
  // that follows edge n+1 (request cycle + 2).
  initial begin : model
    resp_t r;
    bit    exp_rv;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        started     = 1'b1;
        pend.delete();
        exp_dout    = '0;
        dout_known  = 1'b1;
        exp_dropped = 1'b0;
`ifdef DMEM_INIT_EN
        busy_left   = DEPTH;
        exp_mem.delete();
        mem_zeroed  = 1'b1;
`else
        busy_left   = 0;
`endif
      end else if (started) begin
        if (bus.req_valid) begin
          if (busy_left > 0) exp_dropped = 1'b1;
          else if (!bus.mem_wen) exp_mem[int'(bus.mem_addr)] = bus.mem_din;
          else begin
            r.due = cyc + 1;
            if (exp_mem.exists(int'(bus.mem_addr))) begin
              r.data  = exp_mem[int'(bus.mem_addr)];
              r.known = 1'b1;
            end else begin
              r.data  = '0;
              r.known = mem_zeroed;
            end
            pend.push_back(r);
          end
        end
        if (busy_left > 0) busy_left--;
      end

      @(negedge clk);
      if (started) begin
        exp_rv = (pend.size() > 0) && (pend[0].due == cyc);
        if (exp_rv) begin
          r          = pend.pop_front();
          exp_dout   = r.data;
          dout_known = r.known;
        end
        check("resp_valid", 32'(bus.resp_valid), 32'(exp_rv));
        check("busy", 32'(bus.busy), 32'(busy_left > 0));
        check("req_dropped", 32'(bus.req_dropped), 32'(exp_dropped));
        if (dout_known) check("mem_dout", bus.mem_dout, exp_dout);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic req(input logic wen, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.req_valid = 1'b1;
    bus.mem_wen   = wen;
    bus.mem_addr  = a;
    bus.mem_din   = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.mem_wen   = 1'($urandom);
    bus.mem_din   = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_ready(output int cycles);
    cycles = 0;
    while (bus.busy && cycles < DEPTH + 16) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    check("ready_timeout", 32'(bus.busy), 32'd0);
  endtask

  initial begin : stim
    int n;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.mem_wen   = 1'b1;
    bus.mem_addr  = '0;
    bus.mem_din   = '0;
    idle(2);
    rst = 1'b0;

`ifdef DMEM_INIT_EN
    // Write during the sweep is dropped; sweep lasts DEPTH cycles.
    req(1'b0, 12'h055, 32'hA5A5A5A5);
    check("dropped_set", 32'(bus.req_dropped), 32'd1);
    wait_ready(n);
    check("init_busy_cycles", 32'(n + 1), 32'(DEPTH));
    req(1'b1, 12'hFFF, '0);
    idle(1);
    check("init_fff_zero", bus.mem_dout, 32'h0000_0000);
    req(1'b1, 12'h055, '0);
    idle(1);
    check("dropped_no_write", bus.mem_dout, 32'h0000_0000);
    check("dropped_sticky", 32'(bus.req_dropped), 32'd1);
`else
    check("no_init_busy", 32'(bus.busy), 32'd0);
`endif

    // Write then read next cycle: data appears two cycles after the read.
    req(1'b0, 12'h010, 32'hDEADBEEF);
    req(1'b1, 12'h010, '0);
    check("raw_array_stage", 32'(bus.resp_valid), 32'd0);
    idle(1);
    check("raw_valid", 32'(bus.resp_valid), 32'd1);
    check("raw_data", bus.mem_dout, 32'hDEADBEEF);
    idle(1);
    check("raw_single", 32'(bus.resp_valid), 32'd0);
    check("raw_hold", bus.mem_dout, 32'hDEADBEEF);

    // Pipelined reads of 1, 2, 3.
    req(1'b0, 12'h000, 32'd1);
    req(1'b0, 12'h001, 32'd2);
    req(1'b0, 12'h002, 32'd3);
    req(1'b1, 12'h000, '0);
    req(1'b1, 12'h001, '0);
    check("pipe_data0", bus.mem_dout, 32'd1);
    req(1'b1, 12'h002, '0);
    check("pipe_data1", bus.mem_dout, 32'd2);
    idle(1);
    check("pipe_data2", bus.mem_dout, 32'd3);
    check("pipe_valid2", 32'(bus.resp_valid), 32'd1);

    // Reset one cycle after a read is accepted discards it.
    req(1'b0, 12'h020, 32'hCAFEF00D);
    req(1'b1, 12'h020, '0);
    pulse_rst();
    check("rst_inflight_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_dout_zero", bus.mem_dout, 32'd0);
    idle(1);
    check("rst_inflight_valid2", 32'(bus.resp_valid), 32'd0);
    check("rst_dout_zero2", bus.mem_dout, 32'd0);

`ifdef DMEM_INIT_EN
    wait_ready(n);
`else
    // Contents survive reset when the sweep is disabled.
    req(1'b0, 12'h0AB, 32'h12345678);
    pulse_rst();
    req(1'b1, 12'h0AB, '0);
    idle(1);
    check("preserve_data", bus.mem_dout, 32'h12345678);
    check("preserve_busy", 32'(bus.busy), 32'd0);
`endif

    // Randomized traffic over a pre-written window.
    for (int a = 0; a < 32; a++) req(1'b0, ADDR_W'(12'h100 + a), $urandom);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) != 0)
        req(1'($urandom), ADDR_W'(12'h100 + $urandom_range(0, 31)), $urandom);
      else
        idle(1);
`ifndef DMEM_INIT_EN
      if ($urandom_range(0, 249) == 0) pulse_rst();
`endif
    end
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sp_data_mem_resp.md
SP_DATA_MEM_RESP -- requirements
Module: sp_data_mem_resp

Interface
REQ-001 The block SHALL use one clock and one reset: reset is synchronous and active-high.
REQ-002 The block SHALL have parameter ADDR_W, default 12, meaning word-address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, meaning data word width.
REQ-004 The block SHALL have parameter DEPTH, default 4096, meaning number of words (2**ADDR_W).
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  1  processor presents a memory access this cycle.
REQ-008 mem_wen  input  1  active-low write enable: 0 means write, 1 means read.
REQ-009 mem_addr  input  ADDR_W  word address.
REQ-010 mem_din  input  DATA_W  write data.
REQ-011 mem_dout  output  DATA_W  registered read data.
REQ-012 resp_valid  output  1  mem_dout carries read data this cycle.
REQ-013 busy  output  1  block is not accepting requests.
REQ-014 req_dropped  output  1  sticky flag: a request arrived while busy.

Function
REQ-015 The block SHALL accept a request on any rising edge where req_valid=1 and busy=0.
REQ-016 An accepted write (mem_wen=0) SHALL update the word at mem_addr on that edge and SHALL never assert resp_valid.
REQ-017 An accepted read SHALL drive mem_dout and resp_valid=1 exactly 2 cycles after acceptance (array stage, then output register); latency is fixed.
REQ-018 Back-to-back reads SHALL be fully pipelined at one per cycle, with responses in request order.
REQ-019 A read accepted in the cycle after a write to the same address SHALL return the newly written data.
REQ-020 When resp_valid=0, mem_dout SHALL hold its last value.
REQ-021 The FSM SHALL have states INIT and READY: INIT sets busy=1 and steps an ADDR_W counter from 0 to DEPTH-1, writing 0 each cycle; counter wrap at DEPTH-1 moves to READY; READY sets busy=0.
REQ-022 A request with req_valid=1 while busy=1 SHALL be ignored (no write, no response) and SHALL set req_dropped, which only rst clears.
REQ-023 mem_wen and mem_din SHALL be don't-care when req_valid=0.

Reset
REQ-024 When rst=1 on an edge, resp_valid SHALL be 0, mem_dout 0, req_dropped 0, and the init counter 0 on the next cycle.
REQ-025 Reads in flight at reset SHALL be discarded: resp_valid is not asserted for them.
REQ-026 Array contents are not reset except by the INIT sweep (see REQ-027).

Configuration
REQ-027 Macro DMEM_INIT_EN: when defined, reset enters INIT and the clear sweep takes DEPTH cycles; when undefined, reset enters READY directly, busy stays 0, and array contents are preserved across reset (undefined at power-up).

Structure
REQ-028 Package sp_mem_pkg SHALL hold ADDR_W/DATA_W/DEPTH defaults and the FSM state typedef (INIT, READY).
REQ-029 Sub-module sp_mem_array SHALL be a single-port synchronous RAM (one write or one read per cycle, registered Q); sp_data_mem_resp SHALL add the output register, FSM, and flags.

Verification
REQ-030 Write 0xDEADBEEF to addr 0x010, read 0x010 next cycle -> resp_valid and mem_dout=0xDEADBEEF exactly 2 cycles after the read.
REQ-031 Reads to 0x000, 0x001, 0x002 on 3 consecutive cycles, preloaded with 1, 2, 3 -> resp_valid on 3 consecutive cycles with data 1, 2, 3.
REQ-032 With DMEM_INIT_EN: release rst -> busy=1 for 4096 cycles, then 0; read 0xFFF -> 0x00000000.
REQ-033 With DMEM_INIT_EN: write request during INIT -> req_dropped=1, no write happens, and after INIT a read of that address returns 0.
REQ-034 Assert rst one cycle after a read is accepted -> resp_valid stays 0 and mem_dout=0.
REQ-035 Without DMEM_INIT_EN: write 0x12345678 to 0x0AB, pulse rst, read 0x0AB -> 0x12345678 and busy never asserted.
